// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//
// Instruction-memory fetch handshake between the fetch stage and the
// instruction memory.
//
//   imem_req    fetch request, held until imem_ready is seen
//   imem_addr   fetch address (word aligned)
//   imem_ready  memory returns imem_rdata this cycle
//   imem_rdata  instruction word, valid only with imem_ready
//
// master : fetch stage (drives req/addr)
// slave  : instruction memory (drives ready/rdata)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Multi-cycle instruction fetch stage feeding the Controller decode block.
// Holds the PC, fetches one word at a time over a variable-latency req/ready
// handshake, presents the held instruction to decode while it executes, and
// commits the next PC (jump / branch / sequential) when the datapath reports
// completion.
//
// State table:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | just out of reset; moves to ST_FETCH on the next edge
//   ST_FETCH | imem_req high at PC; waits for imem_ready, then latches Instr
//   ST_EXEC  | Instr valid; waits for ExecDone, then commits next PC
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   imem         fetch handshake (master side)
//   Instr        held instruction register (0 = nop after reset)
//   Op, Funct    Instr[31:26], Instr[5:0]
//   InstrValid   Instr is current and executing (ST_EXEC)
//   ExecDone     datapath finished the current instruction
//   PCSrc, Jump  branch-taken / jump, sampled with ExecDone
//   PC           address of the current instruction
//   PCPlus4      PC + 4 (mod 2^32)
//   RetireCnt    committed-instruction count (wraps)
//
// RESET_PC must be word aligned; the low two bits are carried through as-is.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,

    fetch_unit_if.master imem,

    output logic [31:0]  Instr,
    output logic [5:0]   Op,
    output logic [5:0]   Funct,
    output logic         InstrValid,

    input  logic         ExecDone,
    input  logic         PCSrc,
    input  logic         Jump,

    output logic [31:0]  PC,
    output logic [31:0]  PCPlus4,
    output logic [31:0]  RetireCnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] retire_cnt;

    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

    logic        capture;
    logic        commit;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = ST_FETCH;
            ST_FETCH: if (imem.imem_ready) state_nxt = ST_EXEC;
            ST_EXEC:  if (ExecDone)        state_nxt = ST_FETCH;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. Pure state decodes so req and InstrValid have no
    // combinational path from any input and can never overlap.
    // -------------------------------------------------------------------------
    always_comb begin
        imem.imem_req = 1'b0;
        InstrValid    = 1'b0;
        case (state)
            ST_FETCH: imem.imem_req = 1'b1;
            ST_EXEC:  InstrValid    = 1'b1;
            default:  ;
        endcase
    end

    // Handshake events are qualified by state so that stray ready/done pulses
    // in other states have no effect.
    assign capture = (state == ST_FETCH) && imem.imem_ready;
    assign commit  = (state == ST_EXEC)  && ExecDone;

    // -------------------------------------------------------------------------
    // Next-PC selection: Jump > PCSrc > sequential, all modulo 2^32.
    // -------------------------------------------------------------------------
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_off;
    assign jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = jump_target;
        end else if (PCSrc) begin
            next_pc = branch_target;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (commit) begin
            pc_q <= next_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= 32'h0000_0000;
        end else if (capture) begin
            instr_q <= imem.imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= 32'h0000_0000;
        end else if (commit) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Output wiring
    // -------------------------------------------------------------------------
    assign imem.imem_addr = pc_q;
    assign PC             = pc_q;
    assign PCPlus4        = pc_plus4;
    assign Instr          = instr_q;
    assign Op             = instr_q[31:26];
    assign Funct          = instr_q[5:0];
    assign RetireCnt      = retire_cnt;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Multi-cycle instruction fetch stage sitting directly upstream of the `Controller` decode block. It holds the PC and fetches from an instruction memory with a variable-latency req/ready handshake. It presents the held instruction (with `Op`/`Funct` split out) to decode and the datapath. When the datapath signals completion, it commits the next PC using the `PCSrc`/`Jump` outcome that `Controller` produces.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset; must be word-aligned.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; equals `PC`.
- `imem_ready`  in  1  instruction memory returns data this cycle.
- `imem_rdata`  in  32  instruction word; valid only when `imem_ready`=1.
- `Instr`  out  32  held instruction register.
- `Op`  out  6  `Instr[31:26]`, to decode.
- `Funct`  out  6  `Instr[5:0]`, to decode.
- `InstrValid`  out  1  `Instr` is current and executing.
- `ExecDone`  in  1  datapath has finished the current instruction (single-cycle pulse or level).
- `PCSrc`  in  1  branch taken (Branch & Zero), sampled with `ExecDone`.
- `Jump`  in  1  jump, sampled with `ExecDone`.
- `PC`  out  32  address of the current instruction.
- `PCPlus4`  out  32  `PC + 4`, combinational, modulo 2^32.
- `RetireCnt`  out  32  count of committed instructions.

## Operation

- FSM states: IDLE, FETCH, EXEC.
  - IDLE: entered on reset; exits to FETCH unconditionally on the next edge.
  - FETCH: `imem_req`=1, `imem_addr`=`PC`. When `imem_ready`=1 at an edge, `Instr` <= `imem_rdata` and the FSM moves to EXEC.
  - EXEC: `InstrValid`=1. When `ExecDone`=1 at an edge, `PC` <= next PC, `RetireCnt` += 1, and the FSM moves to FETCH.
- Next-PC priority: `Jump` > `PCSrc` > sequential.
  - Jump target: `{PCPlus4[31:28], Instr[25:0], 2'b00}`.
  - Branch target: `PCPlus4 + {{14{Instr[15]}}, Instr[15:0], 2'b00}`, 32-bit wrap, no overflow detection.
  - Sequential: `PCPlus4`; `32'hFFFF_FFFC` wraps to `0`.
- `RetireCnt` wraps from `32'hFFFF_FFFF` to 0.
- `Op`, `Funct` and `Instr` stay stable from the FETCH->EXEC edge until the next FETCH->EXEC edge.
- `imem_ready` outside FETCH is ignored; `imem_rdata` is not captured.
- `ExecDone`, `PCSrc` and `Jump` outside EXEC are ignored; `PC` and `RetireCnt` do not change.

## Timing

- Reset values (async, immediate on `rst_n` low):
  - state = IDLE, `PC` = `RESET_PC`, `Instr` = 0 (nop), `RetireCnt` = 0.
  - `imem_req` = 0, `InstrValid` = 0.
- After `rst_n` rises: edge 1 IDLE->FETCH; `imem_req` is high from the cycle after that edge.
- `imem_req` and `imem_addr` are held constant throughout FETCH until ready is accepted; the request is never withdrawn.
- `imem_ready` may be high in the first FETCH cycle, giving a 1-cycle FETCH.
- Minimum throughput: 2 cycles per instruction (1 FETCH + 1 EXEC).
- `imem_req` and `InstrValid` are mutually exclusive, both registered-state decodes with no combinational path from inputs.
- Next PC is computed combinationally from `Instr`/`PC` and the inputs, and is registered on the `ExecDone` edge.
- Reset asserted mid-FETCH abandons the outstanding request. A late `imem_ready` arriving after reset, during IDLE, is ignored.
- Reset asserted mid-EXEC discards the instruction; it is not counted in `RetireCnt`.

## Test plan

- Reset: hold `rst_n`=0 with `RESET_PC`=`32'h0000_3000` -> `PC`=`0x3000`, `imem_req`=0, `InstrValid`=0, `Instr`=0, `RetireCnt`=0. Release -> `imem_req`=1 with `imem_addr`=`0x3000` one cycle after the IDLE->FETCH edge.
- Zero-wait sequential: ready and `ExecDone` always 1, no branch/jump -> addresses 0x0, 0x4, 0x8… every 2 cycles; `RetireCnt` increments 1 per 2 cycles.
- Wait states: `imem_ready` delayed 3 cycles -> `imem_req`/`imem_addr` held 4 cycles, `InstrValid`=0 throughout. Ready pulse during EXEC -> no change to `Instr`.
- Branch: `Instr`=`0x1000FFFF` at `PC`=`0x10` with `PCSrc`=1 -> next PC `0x10`. `Instr`=`0x10000003` at `0x20` with `PCSrc`=1 -> `0x30`; same with `PCSrc`=0 -> `0x24`.
- Jump priority: `Instr`=`0x08000040` at `PC`=`0xF000_0000`, `Jump`=1 and `PCSrc`=1 -> next PC `0xF000_0100`.
- Boundaries:
  - Reset asserted in FETCH while waiting, then ready arrives in IDLE -> ignored; refetch at `RESET_PC`.
  - Sequential step at `PC`=`0xFFFF_FFFC` -> `PC`=0.
  - `RetireCnt` preloaded to `0xFFFF_FFFF` via forced state -> wraps to 0.
